l1_maxpool: RTL and testbench

//  Consumer end of the layer-0 feature-map read port. Samples 2x2 windows per channel (2 channels).

---
 rtl/l1_maxpool.sv | 96 +++++++++
 tb/tb_l1_maxpool.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/l1_maxpool.sv
// l1_maxpool: 2x2 signed max-pool of two channels into a 13x13 frame buffer, streamed out over valid/ready.
// Build option L1_MAXPOOL_QUANT_EN: requantise each pooled value (arith shift + saturate to OUT_W) at buffer write.
module l1_maxpool #(
  parameter int DW    = 18,
  parameter int N_WIN = 169,
  parameter int AW    = 8,
  parameter int SHIFT = 8,
  parameter int OUT_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            tx_done,
  input  logic            in_rd,
  input  logic [4*DW-1:0] din_0,
  input  logic [4*DW-1:0] din_1,
  output logic            out_vld,
  input  logic            out_rdy,
  output logic [DW-1:0]   dout_0,
  output logic [DW-1:0]   dout_1,
  output logic [AW-1:0]   out_idx,
  output logic            frame_done,
  output logic            ovf
);
`ifdef L1_MAXPOOL_QUANT_EN
  localparam bit QEN = 1'b1;
`else
  localparam bit QEN = 1'b0;
`endif
  localparam logic signed [DW-1:0] SAT = DW'(2**OUT_W - 1);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;
  state_t state, state_nx;
  logic vld_d, cap, hs, wr_last, rd_last;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [DW-1:0] mem_0 [N_WIN];
  logic [DW-1:0] mem_1 [N_WIN];

  function automatic logic signed [DW-1:0] max4(input logic [4*DW-1:0] w);
    logic signed [DW-1:0] m;
    m = w[DW-1:0];
    for (int i = 1; i < 4; i++) m = ($signed(w[i*DW +: DW]) > m) ? w[i*DW +: DW] : m;
    return m;
  endfunction

  function automatic logic [DW-1:0] requant(input logic signed [DW-1:0] m);
    logic signed [DW-1:0] s;
    s = m >>> SHIFT;
    return !QEN ? m : (m <= 0) ? '0 : (s > SAT) ? SAT : s;
  endfunction

  // Samples arriving while draining are dropped; only ovf records them
  assign cap     = vld_d && state != DRAIN;
  assign out_vld = state == DRAIN;
  assign hs      = out_vld && out_rdy;
  assign wr_last = wr_ptr == AW'(N_WIN - 1);
  assign rd_last = rd_ptr == AW'(N_WIN - 1);
  assign out_idx = rd_ptr;
  assign dout_0  = out_vld ? mem_0[rd_ptr] : '0;
  assign dout_1  = out_vld ? mem_1[rd_ptr] : '0;

  always_comb begin
    state_nx = (cap && wr_last) ? DRAIN : cap ? FILL : (hs && rd_last) ? IDLE : state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      vld_d      <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      frame_done <= 1'b0;
      ovf        <= 1'b0;
    end else if (tx_done) begin
      state      <= IDLE;
      vld_d      <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      frame_done <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      state      <= state_nx;
      vld_d      <= in_rd;
      wr_ptr     <= (cap && !wr_last) ? wr_ptr + 1'b1 : (hs && rd_last) ? '0 : wr_ptr;
      rd_ptr     <= hs ? (rd_last ? '0 : rd_ptr + 1'b1) : rd_ptr;
      frame_done <= hs && rd_last;
      ovf        <= ovf | (out_vld && (in_rd || vld_d));
    end
  end

  always_ff @(posedge clk) begin
    if (cap && !tx_done) begin
      mem_0[wr_ptr] <= requant(max4(din_0));
      mem_1[wr_ptr] <= requant(max4(din_1));
    end
  end
endmodule

// File: tb/tb_l1_maxpool.sv
// tb_l1_maxpool: table-driven frames plus directed stall, overflow, abort and reset sequences for l1_maxpool.
module tb_l1_maxpool;
  localparam int DW = 18, N = 169, AW = 8, NT = 6;
`ifdef L1_MAXPOOL_QUANT_EN
  localparam bit Q = 1'b1;
`else
  localparam bit Q = 1'b0;
`endif
  logic clk = 0, rst_n = 0, tx_done = 0, in_rd = 0, out_rdy = 0;
  logic [4*DW-1:0] din_0 = '0, din_1 = '0;
  logic out_vld, frame_done, ovf;
  logic [DW-1:0] dout_0, dout_1;
  logic [AW-1:0] out_idx;

  typedef struct {
    logic [4*DW-1:0] d0;
    logic [4*DW-1:0] d1;
    longint e0;
    longint e1;
  } vec_t;
  vec_t tab [NT];
  longint exp0 [N];
  longint exp1 [N];
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  l1_maxpool dut (
    .clk(clk), .rst_n(rst_n), .tx_done(tx_done), .in_rd(in_rd),
    .din_0(din_0), .din_1(din_1), .out_vld(out_vld), .out_rdy(out_rdy),
    .dout_0(dout_0), .dout_1(dout_1), .out_idx(out_idx),
    .frame_done(frame_done), .ovf(ovf)
  );

  function automatic logic [4*DW-1:0] pk(input int a3, input int a2, input int a1, input int a0);
    return {DW'(a3), DW'(a2), DW'(a1), DW'(a0)};
  endfunction

  function automatic vec_t mk(input int a3, a2, a1, a0, b3, b2, b1, b0,
                              input longint e0_off, e0_on, e1_off, e1_on);
    vec_t v;
    v.d0 = pk(a3, a2, a1, a0);
    v.d1 = pk(b3, b2, b1, b0);
    v.e0 = Q ? e0_on : e0_off;
    v.e1 = Q ? e1_on : e1_off;
    return v;
  endfunction

  task automatic chk(input string nm, input longint act, input longint want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Strobe n windows back-to-back; data follows each strobe by one cycle.
  task automatic fill(input int k0, input int n, input int v);
    for (int j = 0; j <= n; j++) begin
      in_rd = (j < n);
      if (j > 0) begin
        int s;
        s = (v < 0) ? (k0 + j - 1) % NT : v;
        din_0 = tab[s].d0;
        din_1 = tab[s].d1;
        exp0[k0+j-1] = tab[s].e0;
        exp1[k0+j-1] = tab[s].e1;
      end
      step();
    end
    in_rd = 0;
  endtask

  task automatic drain(input bit stall, input int ovf_at);
    int got = 0, cyc = 0;
    bit pulsed = 0;
    while (got < N && cyc < 4 * N) begin
      out_rdy = !stall || (cyc % 4 == 0) || (cyc % 4 == 3);
      in_rd = (ovf_at >= 0) && (got == ovf_at) && !pulsed;
      if (in_rd) pulsed = 1;
      chk("out_vld", out_vld, 1);
      chk("dout_0", $signed(dout_0), exp0[got]);
      chk("dout_1", $signed(dout_1), exp1[got]);
      chk("out_idx", out_idx, got);
      chk("frame_done_low", frame_done, 0);
      if (out_rdy) got++;
      step();
      cyc++;
    end
    out_rdy = 0;
    in_rd = 0;
    chk("drain_count", got, N);
    chk("frame_done", frame_done, 1);
    chk("idle_vld", out_vld, 0);
    step();
    chk("frame_done_pulse", frame_done, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tab[0] = mk(5, 9, 3, 7,             0, 0, 0, 1,                9, 0,        1, 0);
    tab[1] = mk(-4, -2, -9, -3,         -131072, -1, -5, -100,    -2, 0,       -1, 0);
    tab[2] = mk(131071, 0, -1, 100,     2560, 2304, -3, 0,         131071, 255, 2560, 10);
    tab[3] = mk(-131072, -131072, -131072, -131072, 1000, -1000, 999, 300, -131072, 0, 1000, 3);
    tab[4] = mk(300, 12000, 256, -7,    255, 254, 0, 0,            12000, 46,   255, 0);
    tab[5] = mk(1, 2, 3, 70000,         -50, -60, 40, -70,         70000, 255,  40, 0);
    #12 rst_n = 1;
    step();
    chk("rst_vld", out_vld, 0);
    chk("rst_dout_0", dout_0, 0);
    chk("rst_dout_1", dout_1, 0);
    chk("rst_idx", out_idx, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_ovf", ovf, 0);
    // Uniform frame, always ready
    fill(0, N, 0);
    drain(0, -1);
    chk("ovf_quiet", ovf, 0);
    // Mixed table frame under 1,0,0,1 ready pattern
    fill(0, N, -1);
    drain(1, -1);
    // Strobe during drain at word 20
    fill(0, N, 2);
    drain(0, 20);
    chk("ovf_set", ovf, 1);
    tx_done = 1;
    step();
    tx_done = 0;
    chk("ovf_clr", ovf, 0);
    chk("abort_vld", out_vld, 0);
    // Abort after 50 captures, with a capture landing on the abort cycle
    fill(0, 50, 3);
    chk("partial_vld", out_vld, 0);
    in_rd = 1;
    step();
    in_rd = 0;
    tx_done = 1;
    step();
    tx_done = 0;
    chk("abort2_vld", out_vld, 0);
    chk("abort2_idx", out_idx, 0);
    fill(0, N, -1);
    drain(1, -1);
    // Asynchronous reset in the middle of a drain
    fill(0, N, 4);
    out_rdy = 1;
    repeat (10) step();
    #3 rst_n = 0;
    #1;
    chk("arst_vld", out_vld, 0);
    chk("arst_dout_0", dout_0, 0);
    chk("arst_dout_1", dout_1, 0);
    chk("arst_idx", out_idx, 0);
    chk("arst_frame_done", frame_done, 0);
    chk("arst_ovf", ovf, 0);
    out_rdy = 0;
    #2 rst_n = 1;
    step();
    chk("post_rst_vld", out_vld, 0);
    fill(0, 100, 5);
    chk("post_rst_partial_vld", out_vld, 0);
    fill(100, N - 100, -1);
    drain(0, -1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
